// File: rtl/motion_trace_pkg.sv
// Shared geometry, overlay colour and bounding-box record for the motion trace path.
// Used by motion_bbox_detect and its optional overlay (MOTION_BBOX_OVERLAY_EN).
package motion_trace_pkg;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int CRD_W = 10;
  localparam logic [15:0] BOX_COLOR = 16'hF800;

  typedef struct packed {
    logic [CRD_W-1:0] left;
    logic [CRD_W-1:0] right;
    logic [CRD_W-1:0] top;
    logic [CRD_W-1:0] bottom;
    logic             found;
  } bbox_t;

  // True when (x,y) lies on the rectangle outline of b (inclusive edges).
  function automatic logic on_border(input logic [CRD_W-1:0] x,
                                     input logic [CRD_W-1:0] y,
                                     input bbox_t b);
    logic in_x;
    logic in_y;
    in_x = (x >= b.left) && (x <= b.right);
    in_y = (y >= b.top) && (y <= b.bottom);
    return (((x == b.left) || (x == b.right)) && in_y) ||
           (((y == b.top) || (y == b.bottom)) && in_x);
  endfunction

endpackage

// File: rtl/motion_bbox_detect_overlay.sv
// Draws the latched bounding box in red over the pixel stream, delaying
// sync, strobe and pixel data by one clock. Only instantiated with MOTION_BBOX_OVERLAY_EN.
module bbox_overlay
  import motion_trace_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             href,
  input  logic             clken,
  input  logic [15:0]      rgb,
  input  logic [CRD_W-1:0] x,
  input  logic [CRD_W-1:0] y,
  input  bbox_t            box,
  output logic             post_vsync,
  output logic             post_href,
  output logic             post_clken,
  output logic [15:0]      post_rgb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_clken <= 1'b0;
      post_rgb   <= '0;
    end else begin
      post_vsync <= vsync;
      post_href  <= href;
      post_clken <= clken;
      post_rgb   <= (box.found && on_border(x, y, box)) ? BOX_COLOR : rgb;
    end
  end

endmodule

// File: rtl/motion_bbox_detect.sv
// Per-frame bounding box and pixel count of the binary motion mask, published at each
// frame start. Optional red box overlay on the video path: define MOTION_BBOX_OVERLAY_EN.
module motion_bbox_detect
  import motion_trace_pkg::bbox_t;
#(
  parameter int IMG_W   = motion_trace_pkg::IMG_W,
  parameter int IMG_H   = motion_trace_pkg::IMG_H,
  parameter int CRD_W   = motion_trace_pkg::CRD_W,
  parameter int MIN_PIX = 16,
  parameter int CNT_W   = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_bit,
  output logic [CRD_W-1:0] box_left,
  output logic [CRD_W-1:0] box_right,
  output logic [CRD_W-1:0] box_top,
  output logic [CRD_W-1:0] box_bottom,
  output logic [CNT_W-1:0] box_pix_cnt,
  output logic             box_found,
  output logic             box_valid
`ifdef MOTION_BBOX_OVERLAY_EN
  ,
  input  logic [15:0]      pix_rgb,
  output logic             post_vsync,
  output logic             post_href,
  output logic             post_clken,
  output logic [15:0]      post_rgb
`endif
);

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  localparam logic [CRD_W-1:0] X_MAX   = CRD_W'(IMG_W - 1);
  localparam logic [CRD_W-1:0] Y_MAX   = CRD_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state;
  logic             vsync_d;
  logic             href_d;
  logic [CRD_W-1:0] x;
  logic [CRD_W-1:0] y;
  logic [CRD_W-1:0] min_x;
  logic [CRD_W-1:0] max_x;
  logic [CRD_W-1:0] min_y;
  logic [CRD_W-1:0] max_y;
  logic [CNT_W-1:0] cnt;
  bbox_t            box;

  logic sof;
  logic href_fall;
  logic accept;

  assign sof       = per_frame_vsync & ~vsync_d;
  assign href_fall = ~per_frame_href & href_d;
  // A strobe coincident with the frame boundary belongs to neither frame.
  assign accept    = (state == ACTIVE) & per_frame_clken & per_frame_href & ~sof;

  // NOTE: all state here is sequential and uses non-blocking assignments, so every
  // comparison below sees the values from before this edge (e.g. the pre-reset x).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_SOF;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      x           <= '0;
      y           <= '0;
      min_x       <= X_MAX;
      max_x       <= '0;
      min_y       <= Y_MAX;
      max_y       <= '0;
      cnt         <= '0;
      box         <= '0;
      box_pix_cnt <= '0;
      box_valid   <= 1'b0;
    end else begin
      vsync_d   <= per_frame_vsync;
      href_d    <= per_frame_href;
      box_valid <= 1'b0;

      if (sof) begin
        if (state == ACTIVE) begin
          box_pix_cnt <= cnt;
          box_valid   <= 1'b1;
          box.found   <= (cnt >= CNT_W'(MIN_PIX));
          if (cnt >= CNT_W'(MIN_PIX)) begin
            box.left   <= min_x;
            box.right  <= max_x;
            box.top    <= min_y;
            box.bottom <= max_y;
          end
        end
        state <= ACTIVE;
        x     <= '0;
        y     <= '0;
        min_x <= X_MAX;
        max_x <= '0;
        min_y <= Y_MAX;
        max_y <= '0;
        cnt   <= '0;
      end else if (state == ACTIVE) begin
        if (accept) begin
          if (per_img_bit) begin
            if (x < min_x) min_x <= x;
            if (x > max_x) max_x <= x;
            if (y < min_y) min_y <= y;
            if (y > max_y) max_y <= y;
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          end
          if (x != X_MAX) x <= x + 1'b1;
        end
        // End of line overrides the column advance of a pixel in the same cycle.
        if (href_fall) begin
          x <= '0;
          if (y != Y_MAX) y <= y + 1'b1;
        end
      end
    end
  end

  assign box_left   = box.left;
  assign box_right  = box.right;
  assign box_top    = box.top;
  assign box_bottom = box.bottom;
  assign box_found  = box.found;

`ifdef MOTION_BBOX_OVERLAY_EN
  bbox_overlay u_overlay (
    .clk        (clk),
    .rst        (rst),
    .vsync      (per_frame_vsync),
    .href       (per_frame_href),
    .clken      (per_frame_clken),
    .rgb        (pix_rgb),
    .x          (x),
    .y          (y),
    .box        (box),
    .post_vsync (post_vsync),
    .post_href  (post_href),
    .post_clken (post_clken),
    .post_rgb   (post_rgb)
  );
`endif

endmodule

// File: tb/tb_motion_bbox_detect.sv
// Directed bench for motion_bbox_detect: table of rectangle frames plus hand-written
// corner sequences; a second instance with MIN_PIX=2 covers the low-threshold case.
module tb_motion_bbox_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic        clken = 1'b0;
  logic        pix_bit = 1'b0;
  logic [15:0] rgb = '0;

  logic [9:0]  d1_left, d1_right, d1_top, d1_bottom;
  logic [18:0] d1_cnt;
  logic        d1_found, d1_valid;
  logic [9:0]  d2_left, d2_right, d2_top, d2_bottom;
  logic [18:0] d2_cnt;
  logic        d2_found, d2_valid;
`ifdef MOTION_BBOX_OVERLAY_EN
  logic        p1_vsync, p1_href, p1_clken, p2_vsync, p2_href, p2_clken;
  logic [15:0] p1_rgb, p2_rgb;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  motion_bbox_detect dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(pix_bit),
    .box_left(d1_left), .box_right(d1_right), .box_top(d1_top), .box_bottom(d1_bottom),
    .box_pix_cnt(d1_cnt), .box_found(d1_found), .box_valid(d1_valid)
`ifdef MOTION_BBOX_OVERLAY_EN
    , .pix_rgb(rgb), .post_vsync(p1_vsync), .post_href(p1_href),
    .post_clken(p1_clken), .post_rgb(p1_rgb)
`endif
  );

  motion_bbox_detect #(.MIN_PIX(2)) dut_lo (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(pix_bit),
    .box_left(d2_left), .box_right(d2_right), .box_top(d2_top), .box_bottom(d2_bottom),
    .box_pix_cnt(d2_cnt), .box_found(d2_found), .box_valid(d2_valid)
`ifdef MOTION_BBOX_OVERLAY_EN
    , .pix_rgb(rgb), .post_vsync(p2_vsync), .post_href(p2_href),
    .post_clken(p2_clken), .post_rgb(p2_rgb)
`endif
  );

  typedef struct {
    int y0, y1, x0, x1;
    int left, right, top, bottom, cnt;
    bit found;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_d1(input string tag, input int l, input int r, input int t,
                          input int b, input int c, input bit f);
    check({tag, ".left"},   d1_left,   l);
    check({tag, ".right"},  d1_right,  r);
    check({tag, ".top"},    d1_top,    t);
    check({tag, ".bottom"}, d1_bottom, b);
    check({tag, ".cnt"},    d1_cnt,    c);
    check({tag, ".found"},  d1_found,  f);
  endtask

  task automatic check_d2(input string tag, input int l, input int r, input int t,
                          input int b, input int c, input bit f);
    check({tag, ".lo.left"},   d2_left,   l);
    check({tag, ".lo.right"},  d2_right,  r);
    check({tag, ".lo.top"},    d2_top,    t);
    check({tag, ".lo.bottom"}, d2_bottom, b);
    check({tag, ".lo.cnt"},    d2_cnt,    c);
    check({tag, ".lo.found"},  d2_found,  f);
  endtask

  // One href-only cycle, then n_pix strobed pixels; motion on pixel index lo..hi.
  task automatic send_line(input int n_pix, input int lo, input int hi);
    @(negedge clk); href = 1'b1; clken = 1'b0; pix_bit = 1'b0;
    for (int i = 0; i < n_pix; i++) begin
      @(negedge clk); clken = 1'b1; pix_bit = (i >= lo && i <= hi);
    end
    @(negedge clk); href = 1'b0; clken = 1'b0; pix_bit = 1'b0;
    @(negedge clk);
  endtask

  task automatic empty_lines(input int n);
    for (int i = 0; i < n; i++) send_line(0, 1, 0);
  endtask

  task automatic send_rect(input vec_t v);
    if (v.y1 < 0) begin
      repeat (4) @(negedge clk);
    end else begin
      empty_lines(v.y0);
      for (int yy = v.y0; yy <= v.y1; yy++) send_line(v.x1 + 1, v.x0, v.x1);
    end
  endtask

  // Raise vsync once; optionally strobe a motion pixel in the sof cycle.
  task automatic frame_sync(input string tag, input int exp_pulses, input bit strobe);
    int  n;
    logic first;
    @(negedge clk); vsync = 1'b1;
    if (strobe) begin href = 1'b1; clken = 1'b1; pix_bit = 1'b1; end
    @(negedge clk); first = d1_valid; n = int'(d1_valid);
    href = 1'b0; clken = 1'b0; pix_bit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) vsync = 1'b0;
      n += int'(d1_valid);
    end
    check({tag, ".valid_pulses"}, n, exp_pulses);
    if (exp_pulses > 0) check({tag, ".valid_first_cycle"}, first, 1);
  endtask

  function automatic bit tb_border(input int px, input int py);
    return ((px == 100 || px == 119) && py >= 50 && py <= 59) ||
           ((py == 50 || py == 59) && px >= 100 && px <= 119);
  endfunction

`ifdef MOTION_BBOX_OVERLAY_EN
  // Line at y=55 with known pixel colours; post_* checked one clock later.
  task automatic overlay_line(input int n_pix);
    logic        ph, pc;
    logic [15:0] prgb;
    for (int c = 0; c <= n_pix + 1; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("ovl.post_href",  p1_href,  ph);
        check("ovl.post_clken", p1_clken, pc);
        check("ovl.post_vsync", p1_vsync, 0);
        check($sformatf("ovl.post_rgb@c%0d", c - 1), p1_rgb, prgb);
      end
      href    = (c <= n_pix);
      clken   = (c > 0 && c <= n_pix);
      pix_bit = 1'b0;
      rgb     = 16'(c * 37 + 5);
      ph = href; pc = clken;
      prgb = (c <= n_pix && tb_border((c > 0) ? c - 1 : 0, 55)) ? 16'hF800 : rgb;
    end
    href = 1'b0; clken = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          y0  y1  x0   x1   left right top bot cnt  found
    vecs[0] = '{-1, -1,  0,   0,   0,   0,   0,   0,   0, 1'b0};
    vecs[1] = '{50, 59, 100, 119, 100, 119, 50,  59, 200, 1'b1};
    vecs[2] = '{ 2,  5,  7,  10,   7,  10,   2,   5,  16, 1'b1};
    vecs[3] = '{ 1,  3, 20,  24,   7,  10,   2,   5,  15, 1'b0};
    vecs[4] = '{50, 59, 100, 119, 100, 119, 50,  59, 200, 1'b1};

    repeat (3) @(negedge clk);
    check_d1("reset", 0, 0, 0, 0, 0, 0);
    check("reset.valid", d1_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    frame_sync("first_sof", 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_rect(vecs[k]);
      frame_sync($sformatf("vec%0d", k), 1, 1'b0);
      check_d1($sformatf("vec%0d", k), vecs[k].left, vecs[k].right, vecs[k].top,
               vecs[k].bottom, vecs[k].cnt, vecs[k].found);
    end

`ifdef MOTION_BBOX_OVERLAY_EN
    empty_lines(55);
    overlay_line(102);
    frame_sync("ovl_frame", 1, 1'b0);
    check_d1("ovl_frame", 100, 119, 50, 59, 0, 0);
`endif

    for (int yy = 0; yy < 5; yy++) send_line(20, 2 * yy + 1, 2 * yy + 1);
    frame_sync("sparse", 1, 1'b0);
    check_d1("sparse", 100, 119, 50, 59, 5, 0);
    check_d2("sparse", 1, 9, 0, 4, 5, 1);

    // (0,0), then x and y both driven past their limits to land on (639,479).
    send_line(1, 0, 0);
    empty_lines(480);
    send_line(642, 641, 641);
    frame_sync("corners", 1, 1'b0);
    check_d1("corners", 100, 119, 50, 59, 2, 0);
    check_d2("corners", 0, 639, 0, 479, 2, 1);

    send_line(3, 0, 2);
    frame_sync("sof_strobe", 1, 1'b1);
    check_d1("sof_strobe", 100, 119, 50, 59, 3, 0);
    frame_sync("after_drop", 1, 1'b0);
    check("after_drop.cnt", d1_cnt, 0);

    send_line(10, 0, 9);
    @(negedge clk); rst = 1'b1;
    #1;
    check_d1("mid_reset", 0, 0, 0, 0, 0, 0);
    check("mid_reset.valid", d1_valid, 0);
    @(negedge clk); rst = 1'b0;
    send_line(10, 0, 9);
    frame_sync("post_reset_sof", 0, 1'b0);
    for (int yy = 0; yy < 4; yy++) send_line(10, 5, 9);
    frame_sync("recover", 1, 1'b0);
    check_d1("recover", 5, 9, 0, 3, 20, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
